adaptive_binarization: RTL and testbench
========================================

# adaptive_binarization

Parametrised binarization engine, successor to the fixed 8-bit global-threshold binarizer. Scans an external pixel RAM of 2**ADDR_W pixels, optionally computing the frame mean in a statistics pass, then writes a 1-bit result per pixel using either an absolute threshold or mean-plus-offset, with optional inversion. Sits between the frame-buffer RAM and the binary-image RAM, driven by the same `int_ctrl`/`bin_ctrl` push-button style start pulses, with status shown on `condition_led`.

## Interface
- PIX_W, 8, pixel bit width
- ADDR_W, 16, address width; frame holds N = 2**ADDR_W pixels (must be power of two)

- bin_clk  in  1  clock, rising edge
- bin_rst  in  1  reset, asynchronous, active-high
- int_ctrl  in  1  start statistics (mean) pass; rising-edge triggered, any pulse length
- bin_ctrl  in  1  start binarization pass; rising-edge triggered
- mode  in  2  bit0: 1 = threshold from mean, 0 = absolute; bit1: invert output
- thres_length  in  PIX_W  absolute threshold (mode[0]=0) or offset added to mean (mode[0]=1)
- pixel_address  out  ADDR_W  read address to pixel RAM
- pixel_data  in  PIX_W  RAM read data, valid one cycle after address (registered RAM)
- bin_addr  out  ADDR_W  write address to binary RAM
- bin_data  out  1  binary result
- bin_we  out  1  write enable, one cycle per pixel
- mean_value  out  PIX_W  last computed frame mean
- condition_led  out  2  00 idle, 01 statistics pass, 10 binarization pass, 11 done

## Operation
- FSM: IDLE, STAT, BIN, DONE. Reset -> IDLE; all outputs 0, mean_value 0, accumulator 0, edge-detect registers 0.
- Start edge = input high and its registered previous sample low; held-high inputs do not retrigger.
- IDLE or DONE: int_ctrl edge -> STAT; else bin_ctrl edge -> BIN. Simultaneous edges: int_ctrl wins, bin_ctrl edge discarded.
- STAT/BIN: edges on either start input ignored (not queued).
- On entering BIN, mode and thres_length latched; changes mid-pass have no effect.
- Address counter: 0 on pass entry, +1 per cycle up to N-1, then holds; pixel_address = 0 in IDLE/DONE.
- STAT: accumulator width PIX_W+ADDR_W, cleared on entry, adds each returned pixel; at pass end mean_value = acc >> ADDR_W (truncating). No write enables in STAT.
- BIN: threshold T = thres_length (mode[0]=0) or min(mean_value + thres_length, 2**PIX_W-1) (mode[0]=1), computed in PIX_W+1 bits, saturated. bin_data = (pixel > T) XOR mode[1]; equality gives 0 before inversion.
- BIN before any STAT uses mean_value = 0.
- DONE holds until next start edge; outputs bin_we = 0.
- Reset mid-pass: immediate return to IDLE, mean_value cleared, no further writes.

## Timing
- Edge sampled at clock edge E0 -> state and condition_led change, pixel_address = 0 visible in cycle 0 after E0.
- Address for pixel k presented in cycle k (k = 0..N-1); pixel_data for it sampled at end of cycle k+1.
- BIN: bin_we = 1, bin_addr = k, bin_data registered, visible in cycle k+2; exactly N write cycles, contiguous, ascending.
- Pass end: state -> DONE at start of cycle N+2; condition_led = 11 and updated mean_value visible same cycle.
- Pass length from E0 to DONE: N+2 cycles. No backpressure.

## Test plan
- Reset: assert bin_rst asynchronously mid-cycle -> all outputs 0 immediately, condition_led = 00.
- ADDR_W=4, ramp pixels 0,16,...,240; mode=00, thres_length=100 -> bin_data 0 for k<=6, 1 for k>=7; 16 writes in cycles 2..17; DONE at cycle 18.
- Same RAM, int_ctrl pulse held 10 cycles -> one STAT pass only, mean_value = 120 (1920>>4), no bin_we; then bin_ctrl with mode=01, thres_length=5 -> T=125, 1 for k>=8.
- mode=11, mean 120, thres_length=200 -> T saturates 255, all pixels give 0 before invert -> all bin_data = 1.
- int_ctrl and bin_ctrl edges same cycle -> STAT only; bin_ctrl edge during STAT ignored, FSM ends in DONE without BIN.
- bin_rst asserted at cycle 8 of BIN -> bin_we drops immediately, mean_value 0, next bin_ctrl restarts from address 0.

Source files
------------

// File: rtl/adaptive_binarization.sv
// Frame binarizer: optional mean-statistics pass over an external pixel RAM, then a
// 1-bit-per-pixel write pass using an absolute or mean-plus-offset threshold.
module adaptive_binarization #(
    parameter int PIX_W  = 8,
    parameter int ADDR_W = 16
) (
    input  logic              bin_clk,
    input  logic              bin_rst,
    input  logic              int_ctrl,
    input  logic              bin_ctrl,
    input  logic [1:0]        mode,
    input  logic [PIX_W-1:0]  thres_length,
    output logic [ADDR_W-1:0] pixel_address,
    input  logic [PIX_W-1:0]  pixel_data,
    output logic [ADDR_W-1:0] bin_addr,
    output logic              bin_data,
    output logic              bin_we,
    output logic [PIX_W-1:0]  mean_value,
    output logic [1:0]        condition_led
);

    localparam int ACC_W = PIX_W + ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        STAT = 2'b01,
        BIN  = 2'b10,
        DONE = 2'b11
    } state_t;

    state_t state, next_state;

    logic              int_prev, bin_prev;
    logic              int_edge, bin_edge;
    logic              start_stat, start_bin;
    logic              in_pass, pass_end;
    logic [ADDR_W-1:0] addr_p0, addr_p1, addr_p2;
    logic              vld_p0, vld_p1, vld_p2;
    logic [ACC_W-1:0]  acc;
    logic [1:0]        mode_l;
    logic [PIX_W-1:0]  thres_l;
    logic [PIX_W-1:0]  threshold;

    // Mean plus offset can overflow PIX_W bits, so it is formed one bit wider and clamped.
    function automatic logic [PIX_W-1:0] sat_threshold(
        input logic             use_mean,
        input logic [PIX_W-1:0] mean,
        input logic [PIX_W-1:0] offset
    );
        logic [PIX_W:0] sum;
        sum = {1'b0, mean} + {1'b0, offset};
        if (!use_mean)
            return offset;
        else if (sum[PIX_W])
            return {PIX_W{1'b1}};
        else
            return sum[PIX_W-1:0];
    endfunction

    assign int_edge  = int_ctrl & ~int_prev;
    assign bin_edge  = bin_ctrl & ~bin_prev;
    assign in_pass   = (state == STAT) || (state == BIN);
    assign pass_end  = vld_p2 && (addr_p2 == LAST_ADDR);
    assign threshold = sat_threshold(mode_l[0], mean_value, thres_l);

    assign pixel_address = in_pass ? addr_p0 : '0;
    assign bin_addr      = addr_p2;
    assign bin_we        = vld_p2 && (state == BIN);
    assign condition_led = state;

    always_ff @(posedge bin_clk or posedge bin_rst) begin
        if (bin_rst)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        start_stat = 1'b0;
        start_bin  = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (int_edge) begin
                    next_state = STAT;
                    start_stat = 1'b1;
                end else if (bin_edge) begin
                    next_state = BIN;
                    start_bin  = 1'b1;
                end
            end
            STAT, BIN: begin
                if (pass_end)
                    next_state = DONE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge bin_clk or posedge bin_rst) begin
        if (bin_rst) begin
            int_prev   <= 1'b0;
            bin_prev   <= 1'b0;
            addr_p0    <= '0;
            vld_p0     <= 1'b0;
            addr_p1    <= '0;
            vld_p1     <= 1'b0;
            addr_p2    <= '0;
            vld_p2     <= 1'b0;
            acc        <= '0;
            mode_l     <= '0;
            thres_l    <= '0;
            bin_data   <= 1'b0;
            mean_value <= '0;
        end else begin
            int_prev <= int_ctrl;
            bin_prev <= bin_ctrl;

            // p0: address issue, one per cycle, holding at the last pixel
            if (start_stat || start_bin) begin
                addr_p0 <= '0;
                vld_p0  <= 1'b1;
            end else if (vld_p0) begin
                if (addr_p0 == LAST_ADDR)
                    vld_p0 <= 1'b0;
                else
                    addr_p0 <= addr_p0 + ADDR_W'(1);
            end

            // p1: registered RAM returns the pixel addressed in the previous cycle
            vld_p1  <= vld_p0;
            addr_p1 <= addr_p0;

            // p2: accumulate or compare the returned pixel
            vld_p2  <= vld_p1;
            addr_p2 <= addr_p1;

            if (start_stat)
                acc <= '0;
            else if (vld_p1 && (state == STAT))
                acc <= acc + {{ADDR_W{1'b0}}, pixel_data};

            if (start_bin) begin
                mode_l  <= mode;
                thres_l <= thres_length;
            end

            if (vld_p1 && (state == BIN))
                bin_data <= (pixel_data > threshold) ^ mode_l[1];

            if (pass_end && (state == STAT))
                mean_value <= acc[ACC_W-1:ADDR_W];
        end
    end

endmodule

// File: tb/tb_adaptive_binarization.sv
// Bench for adaptive_binarization: a pass-level model predicts every output per cycle
// from the pixel array, start pulses and latched settings; directed and random passes.
module tb_adaptive_binarization;

    localparam int PIX_W  = 8;
    localparam int ADDR_W = 4;
    localparam int N      = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              int_ctrl = 1'b0;
    logic              bin_ctrl = 1'b0;
    logic [1:0]        mode = 2'b00;
    logic [PIX_W-1:0]  thres_length = '0;
    logic [ADDR_W-1:0] pixel_address;
    logic [PIX_W-1:0]  pixel_data = '0;
    logic [ADDR_W-1:0] bin_addr;
    logic              bin_data;
    logic              bin_we;
    logic [PIX_W-1:0]  mean_value;
    logic [1:0]        condition_led;

    int ram [N];
    int errors = 0;
    int checks = 0;

    // model state: phase 0 idle, 1 stat, 2 bin, 3 done; m_k = cycle index within pass
    int m_phase = 0;
    int m_k     = 0;
    int m_mean  = 0;
    int m_mode  = 0;
    int m_thr   = 0;
    bit m_ip    = 1'b0;
    bit m_bp    = 1'b0;
    bit m_ie, m_be;

    adaptive_binarization #(.PIX_W(PIX_W), .ADDR_W(ADDR_W)) dut (
        .bin_clk       (clk),
        .bin_rst       (rst),
        .int_ctrl      (int_ctrl),
        .bin_ctrl      (bin_ctrl),
        .mode          (mode),
        .thres_length  (thres_length),
        .pixel_address (pixel_address),
        .pixel_data    (pixel_data),
        .bin_addr      (bin_addr),
        .bin_data      (bin_data),
        .bin_we        (bin_we),
        .mean_value    (mean_value),
        .condition_led (condition_led)
    );

    always #5 clk = ~clk;

    always @(posedge clk) pixel_data <= 8'(ram[pixel_address]);

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int frame_mean();
        int s = 0;
        for (int i = 0; i < N; i++) s += ram[i];
        return s / N;
    endfunction

    function automatic int expected_bit(input int k);
        int t;
        if (m_mode % 2 == 1) t = (m_mean + m_thr > 255) ? 255 : m_mean + m_thr;
        else t = m_thr;
        return ((ram[k] > t) ? 1 : 0) ^ ((m_mode >> 1) & 1);
    endfunction

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_phase = 0; m_k = 0; m_mean = 0; m_ip = 1'b0; m_bp = 1'b0;
        end else begin
            m_ie = int_ctrl && !m_ip;
            m_be = bin_ctrl && !m_bp;
            m_ip = int_ctrl;
            m_bp = bin_ctrl;
            if (m_phase == 1 || m_phase == 2) begin
                m_k++;
                if (m_k == N + 2) begin
                    if (m_phase == 1) m_mean = frame_mean();
                    m_phase = 3;
                end
            end else if (m_ie) begin
                m_phase = 1; m_k = 0;
            end else if (m_be) begin
                m_phase = 2; m_k = 0; m_mode = int'(mode); m_thr = int'(thres_length);
            end
        end
    end

    initial forever begin
        int exp_pa, exp_we;
        @(negedge clk);
        exp_pa = (m_phase == 1 || m_phase == 2) ? ((m_k < N - 1) ? m_k : N - 1) : 0;
        exp_we = (m_phase == 2 && m_k >= 2) ? 1 : 0;
        check("condition_led", int'(condition_led), m_phase);
        check("pixel_address", int'(pixel_address), exp_pa);
        check("bin_we", int'(bin_we), exp_we);
        if (exp_we == 1) begin
            check("bin_addr", int'(bin_addr), m_k - 2);
            check("bin_data", int'(bin_data), expected_bit(m_k - 2));
        end
        check("mean_value", int'(mean_value), m_mean);
    end

    // sel: 0 int_ctrl, 1 bin_ctrl, 2 both; other_at pulses bin_ctrl mid-pass; rst_at resets mid-pass
    task automatic run_pass(input int sel, input int hold, input int other_at, input int rst_at,
                            output int done_c, output int writes, output int ones);
        done_c = -1; writes = 0; ones = 0;
        @(posedge clk); #2;
        if (sel != 1) int_ctrl = 1'b1;
        if (sel != 0) bin_ctrl = 1'b1;
        @(posedge clk);
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (bin_we) begin writes++; ones += int'(bin_data); end
            if (condition_led == 2'b11 && done_c < 0) done_c = c;
            if (c == hold - 1) begin int_ctrl = 1'b0; bin_ctrl = 1'b0; end
            if (c == other_at) bin_ctrl = 1'b1;
            if (c == other_at + 1) bin_ctrl = 1'b0;
            if (c == 3) begin mode = 2'($urandom); thres_length = 8'($urandom); end
            if (c == rst_at) begin
                #1 rst = 1'b1;
                #1;
                check("rst_bin_we", int'(bin_we), 0);
                check("rst_led", int'(condition_led), 0);
                check("rst_mean", int'(mean_value), 0);
                check("rst_pixel_address", int'(pixel_address), 0);
                @(posedge clk); #2 rst = 1'b0;
                break;
            end
            if (done_c >= 0 && c >= hold && c > other_at + 1) break;
        end
        int_ctrl = 1'b0;
        bin_ctrl = 1'b0;
    endtask

    initial begin
        int dc, w, o, sel;
        for (int i = 0; i < N; i++) ram[i] = i * 16;
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("reset_led", int'(condition_led), 0);
        check("reset_bin_we", int'(bin_we), 0);
        check("reset_bin_data", int'(bin_data), 0);
        check("reset_bin_addr", int'(bin_addr), 0);
        check("reset_mean", int'(mean_value), 0);

        mode = 2'b00; thres_length = 8'd100;
        run_pass(1, 1, -1, -1, dc, w, o);
        check("abs_done_cycle", dc, 18);
        check("abs_writes", w, 16);
        check("abs_ones", o, 9);

        run_pass(0, 10, -1, -1, dc, w, o);
        check("stat_done_cycle", dc, 18);
        check("stat_writes", w, 0);
        check("stat_mean", int'(mean_value), 120);

        mode = 2'b01; thres_length = 8'd5;
        run_pass(1, 1, -1, -1, dc, w, o);
        check("mean_ones", o, 8);

        mode = 2'b11; thres_length = 8'd200;
        run_pass(1, 1, -1, -1, dc, w, o);
        check("sat_inv_ones", o, 16);

        run_pass(2, 1, 5, -1, dc, w, o);
        check("both_done_cycle", dc, 18);
        check("both_writes", w, 0);
        @(negedge clk);
        check("both_stays_done", int'(condition_led), 3);

        mode = 2'b00; thres_length = 8'd100;
        run_pass(1, 1, -1, 8, dc, w, o);
        check("rst_writes_before", w, 7);
        mode = 2'b00; thres_length = 8'd100;
        run_pass(1, 1, -1, -1, dc, w, o);
        check("after_rst_writes", w, 16);
        check("after_rst_ones", o, 9);

        for (int it = 0; it < 14; it++) begin
            for (int i = 0; i < N; i++) ram[i] = $urandom_range(0, 255);
            mode = 2'($urandom);
            thres_length = 8'($urandom);
            sel = $urandom_range(0, 2);
            run_pass(sel, $urandom_range(1, 4), -1, -1, dc, w, o);
            check("rand_done_cycle", dc, 18);
            check("rand_writes", w, (sel == 1) ? 16 : 0);
        end

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
